tx_lbuf_rd_ctrl: RTL and testbench

//  Line-buffer read controller directly upstream of the TX byte data generator.

---
 rtl/tx_lbuf_rd_ctrl_if.sv | 47 ++++
 rtl/tx_lbuf_rd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tx_lbuf_rd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_lbuf_rd_ctrl_if.sv
// Handshake/bus bundle between the TX line-buffer read controller and its
// line buffers (ready/length/ack, RAM read port) and the byte data generator.
interface tx_lbuf_rd_ctrl_if #(
  parameter int DW     = 32,
  parameter int ADDR_W = 11
);
  logic              line_rdy_ch0_i;
  logic              line_rdy_ch1_i;
  logic [15:0]       line_wc_ch0_i;
  logic [15:0]       line_wc_ch1_i;
  logic              line_ack_ch0_o;
  logic              line_ack_ch1_o;
  logic              rd_en_ch0_o;
  logic [ADDR_W-1:0] rd_addr_ch0_o;
  logic              rd_en_ch1_o;
  logic [ADDR_W-1:0] rd_addr_ch1_o;
  logic [DW-1:0]     ram_dout_ch0_i;
  logic [DW-1:0]     ram_dout_ch1_i;
  logic [DW-1:0]     byte_bufout_ch0;
  logic [DW-1:0]     byte_bufout_ch1;
  logic              lbfr_wdvalid_ch0;
  logic              lbfr_wdvalid_ch1;
  logic              lbf_lastwd_ch0;
  logic              lbf_lastwd_ch1;
  logic [15:0]       rd_counter_ch0;
  logic              wc_err_o;

  modport master (
    input  line_rdy_ch0_i, line_rdy_ch1_i, line_wc_ch0_i, line_wc_ch1_i,
    input  ram_dout_ch0_i, ram_dout_ch1_i,
    output line_ack_ch0_o, line_ack_ch1_o,
    output rd_en_ch0_o, rd_addr_ch0_o, rd_en_ch1_o, rd_addr_ch1_o,
    output byte_bufout_ch0, byte_bufout_ch1,
    output lbfr_wdvalid_ch0, lbfr_wdvalid_ch1, lbf_lastwd_ch0, lbf_lastwd_ch1,
    output rd_counter_ch0, wc_err_o
  );

  modport slave (
    output line_rdy_ch0_i, line_rdy_ch1_i, line_wc_ch0_i, line_wc_ch1_i,
    output ram_dout_ch0_i, ram_dout_ch1_i,
    input  line_ack_ch0_o, line_ack_ch1_o,
    input  rd_en_ch0_o, rd_addr_ch0_o, rd_en_ch1_o, rd_addr_ch1_o,
    input  byte_bufout_ch0, byte_bufout_ch1,
    input  lbfr_wdvalid_ch0, lbfr_wdvalid_ch1, lbf_lastwd_ch0, lbf_lastwd_ch1,
    input  rd_counter_ch0, wc_err_o
  );
endinterface

// File: rtl/tx_lbuf_rd_ctrl.sv
// Line-buffer read controller: alternates between the ch0/ch1 line buffers,
// reads one whole line per grant and forwards the words to the TX byte generator.
module tx_lbuf_rd_ctrl #(
  parameter int PP_TX_GEAR = 8,
  parameter int PP_NO_LANE = 4,
  parameter int ADDR_W     = 11,
  parameter int RD_LAT     = 1,
  parameter int GAP_CYC    = 4
) (
  input logic               tx_clk,
  input logic               rst_i,
  tx_lbuf_rd_ctrl_if.master bus
);
  localparam int DW  = PP_TX_GEAR * PP_NO_LANE;
  localparam int WCW = ADDR_W + 1;
  localparam logic [WCW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RD0, RD1, GAP} state_t;

  state_t            state;
  logic [WCW-1:0]    wc;
  logic [WCW-1:0]    rcnt;
  logic [3:0]        gap_cnt;
  logic              last_srv;
  logic              rd_en0, rd_en1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              ack0, ack1;
  logic              wc_err;

  logic              pick1, any_rdy, wc_over, grant0;
  logic [15:0]       sel_wc;
  logic [WCW-1:0]    wc_grant, rcnt_nxt, wc_m1;

  logic [RD_LAT-1:0] pipe_en0, pipe_en1, pipe_last0, pipe_last1;
  logic [DW-1:0]     dout0, dout1;
  logic              wdv0, wdv1, lastwd0, lastwd1;
  logic [15:0]       rd_cnt0;

  // Round-robin pick; ch1 wins a tie only when ch0 was served last.
  always_comb begin
    any_rdy  = bus.line_rdy_ch0_i || bus.line_rdy_ch1_i;
    pick1    = bus.line_rdy_ch1_i && (!bus.line_rdy_ch0_i || !last_srv);
    sel_wc   = pick1 ? bus.line_wc_ch1_i : bus.line_wc_ch0_i;
    wc_over  = sel_wc > 16'(DEPTH);
    wc_grant = wc_over ? DEPTH : sel_wc[WCW-1:0];
    rcnt_nxt = rcnt + WCW'(1);
    wc_m1    = wc - WCW'(1);
    grant0   = (state == IDLE) && bus.line_rdy_ch0_i && !pick1;
  end

  // The ack is raised together with the final read so the buffer is freed
  // on the last-address cycle; a zero-length line acks on its only RD cycle.
  always_ff @(posedge tx_clk) begin
    if (rst_i) begin
      state    <= IDLE;
      wc       <= '0;
      rcnt     <= '0;
      gap_cnt  <= '0;
      last_srv <= 1'b1;
      rd_en0   <= 1'b0;
      rd_en1   <= 1'b0;
      addr0    <= '0;
      addr1    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      wc_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_rdy) begin
            wc     <= wc_grant;
            rcnt   <= '0;
            addr0  <= '0;
            addr1  <= '0;
            if (wc_over) wc_err <= 1'b1;
            state  <= pick1 ? RD1 : RD0;
            rd_en0 <= !pick1 && (wc_grant != '0);
            rd_en1 <= pick1 && (wc_grant != '0);
            ack0   <= !pick1 && (wc_grant <= WCW'(1));
            ack1   <= pick1 && (wc_grant <= WCW'(1));
          end
        end
        RD0, RD1: begin
          if (ack0 || ack1) begin
            rd_en0   <= 1'b0;
            rd_en1   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            addr0    <= '0;
            addr1    <= '0;
            last_srv <= (state == RD1);
            gap_cnt  <= '0;
            state    <= (GAP_CYC == 0) ? IDLE : GAP;
          end else begin
            rcnt <= rcnt_nxt;
            if (state == RD0) begin
              addr0 <= rcnt_nxt[ADDR_W-1:0];
              ack0  <= (rcnt_nxt == wc_m1);
            end else begin
              addr1 <= rcnt_nxt[ADDR_W-1:0];
              ack1  <= (rcnt_nxt == wc_m1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYC - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enable/last travel alongside the RAM latency so the word is captured
  // exactly when the RAM presents it.
  always_ff @(posedge tx_clk) begin
    if (rst_i) begin
      pipe_en0   <= '0;
      pipe_en1   <= '0;
      pipe_last0 <= '0;
      pipe_last1 <= '0;
      dout0      <= '0;
      dout1      <= '0;
      wdv0       <= 1'b0;
      wdv1       <= 1'b0;
      lastwd0    <= 1'b0;
      lastwd1    <= 1'b0;
      rd_cnt0    <= '0;
    end else begin
      pipe_en0[0]   <= rd_en0;
      pipe_en1[0]   <= rd_en1;
      pipe_last0[0] <= rd_en0 && ack0;
      pipe_last1[0] <= rd_en1 && ack1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_en0[i]   <= pipe_en0[i-1];
        pipe_en1[i]   <= pipe_en1[i-1];
        pipe_last0[i] <= pipe_last0[i-1];
        pipe_last1[i] <= pipe_last1[i-1];
      end
      wdv0    <= pipe_en0[RD_LAT-1];
      wdv1    <= pipe_en1[RD_LAT-1];
      lastwd0 <= pipe_last0[RD_LAT-1];
      lastwd1 <= pipe_last1[RD_LAT-1];
      if (pipe_en0[RD_LAT-1]) dout0 <= bus.ram_dout_ch0_i;
      if (pipe_en1[RD_LAT-1]) dout1 <= bus.ram_dout_ch1_i;
      if (grant0) rd_cnt0 <= '0;
      else if (pipe_en0[RD_LAT-1]) rd_cnt0 <= rd_cnt0 + 16'd1;
    end
  end

  assign bus.line_ack_ch0_o   = ack0;
  assign bus.line_ack_ch1_o   = ack1;
  assign bus.rd_en_ch0_o      = rd_en0;
  assign bus.rd_addr_ch0_o    = addr0;
  assign bus.rd_en_ch1_o      = rd_en1;
  assign bus.rd_addr_ch1_o    = addr1;
  assign bus.byte_bufout_ch0  = dout0;
  assign bus.byte_bufout_ch1  = dout1;
  assign bus.lbfr_wdvalid_ch0 = wdv0;
  assign bus.lbfr_wdvalid_ch1 = wdv1;
  assign bus.lbf_lastwd_ch0   = lastwd0;
  assign bus.lbf_lastwd_ch1   = lastwd1;
  assign bus.rd_counter_ch0   = rd_cnt0;
  assign bus.wc_err_o         = wc_err;
endmodule

// File: tb/tb_tx_lbuf_rd_ctrl.sv
// Directed bench for tx_lbuf_rd_ctrl: a cycle table for a single ch0 line, then
// hand-written sequences for arbitration, zero-length, oversize and reset cases.
module tb_tx_lbuf_rd_ctrl;
  logic tx_clk = 1'b0;
  logic rst_i;

  tx_lbuf_rd_ctrl_if #(.DW(32), .ADDR_W(11)) bus ();

  tx_lbuf_rd_ctrl #(
    .PP_TX_GEAR(8), .PP_NO_LANE(4), .ADDR_W(11), .RD_LAT(1), .GAP_CYC(4)
  ) dut (
    .tx_clk(tx_clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 tx_clk = ~tx_clk;

  // One-cycle-latency RAM models: ch0 word = addr+0x100, ch1 word = addr+0x200.
  always @(posedge tx_clk) begin
    if (bus.rd_en_ch0_o) bus.ram_dout_ch0_i <= 32'h100 + 32'(bus.rd_addr_ch0_o);
    if (bus.rd_en_ch1_o) bus.ram_dout_ch1_i <= 32'h200 + 32'(bus.rd_addr_ch1_o);
  end

  typedef struct {
    logic        rst;
    logic        rdy0;
    logic [15:0] wc0;
    logic        en0;
    logic [10:0] addr0;
    logic        ack0;
    logic        wdv0;
    logic        last0;
    logic [31:0] data0;
    logic [15:0] cnt0;
    logic        en1;
    logic        wdv1;
  } vec_t;

  vec_t vecs[12];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int rd_cnt[2], wd_cnt[2], rd_line[2], wd_line[2], first_rd[2], last_rd[2], last_idx[2];
  int addr_err, data_err, last_err, overlap_err, cnt_at_last;
  int left0, left1;
  int acks[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i                = v.rst;
    bus.line_rdy_ch0_i   = v.rdy0;
    bus.line_wc_ch0_i    = v.wc0;
    bus.line_rdy_ch1_i   = 1'b0;
    bus.line_wc_ch1_i    = 16'd0;
    @(posedge tx_clk);
    @(negedge tx_clk);
  endtask

  task automatic resetStats();
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      rd_cnt[c] = 0; wd_cnt[c] = 0; rd_line[c] = 0; wd_line[c] = 0;
      first_rd[c] = -1; last_rd[c] = -1; last_idx[c] = -1;
    end
    addr_err = 0; data_err = 0; last_err = 0; overlap_err = 0; cnt_at_last = -1;
    acks.delete();
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    bus.line_rdy_ch0_i = 1'b0;
    bus.line_rdy_ch1_i = 1'b0;
    left0 = 0;
    left1 = 0;
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk);
    rst_i = 1'b0;
    resetStats();
  endtask

  task automatic monChannel(input int ch, input logic en, input logic [10:0] addr, input logic wdv,
                            input logic last, input logic [31:0] data, input logic ack,
                            input logic [31:0] base);
    if (en) begin
      if (int'(addr) != rd_line[ch]) addr_err++;
      rd_line[ch]++;
      rd_cnt[ch]++;
      if (first_rd[ch] < 0) first_rd[ch] = cyc;
      last_rd[ch] = cyc;
    end
    if (wdv) begin
      if (data !== base + 32'(wd_line[ch])) data_err++;
      wd_line[ch]++;
      wd_cnt[ch]++;
      if (last) begin
        last_idx[ch] = wd_line[ch];
        if (ch == 0) cnt_at_last = int'(bus.rd_counter_ch0);
        wd_line[ch] = 0;
      end
    end else if (last) begin
      last_err++;
    end
    if (ack) begin
      acks.push_back(ch);
      rd_line[ch] = 0;
    end
  endtask

  // One clock; observe at the falling edge, then let the line source react to acks.
  task automatic stepCycle();
    @(posedge tx_clk);
    @(negedge tx_clk);
    cyc++;
    monChannel(0, bus.rd_en_ch0_o, bus.rd_addr_ch0_o, bus.lbfr_wdvalid_ch0, bus.lbf_lastwd_ch0,
               bus.byte_bufout_ch0, bus.line_ack_ch0_o, 32'h100);
    monChannel(1, bus.rd_en_ch1_o, bus.rd_addr_ch1_o, bus.lbfr_wdvalid_ch1, bus.lbf_lastwd_ch1,
               bus.byte_bufout_ch1, bus.line_ack_ch1_o, 32'h200);
    if (bus.lbfr_wdvalid_ch0 && bus.lbfr_wdvalid_ch1) overlap_err++;
    if (bus.line_ack_ch0_o) begin
      bus.line_rdy_ch0_i = 1'b0;
      left0--;
    end else if (!bus.line_rdy_ch0_i && left0 > 0) begin
      bus.line_rdy_ch0_i = 1'b1;
    end
    if (bus.line_ack_ch1_o) begin
      bus.line_rdy_ch1_i = 1'b0;
      left1--;
    end else if (!bus.line_rdy_ch1_i && left1 > 0) begin
      bus.line_rdy_ch1_i = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1;
    bus.line_rdy_ch0_i = 1'b0;
    bus.line_rdy_ch1_i = 1'b0;
    bus.line_wc_ch0_i  = 16'd0;
    bus.line_wc_ch1_i  = 16'd0;
    bus.ram_dout_ch0_i = 32'd0;
    bus.ram_dout_ch1_i = 32'd0;
    left0 = 0;
    left1 = 0;
    resetStats();

    //          rst   rdy0  wc0    en0   addr0  ack0  wdv0  last0 data0     cnt0   en1   wdv1
    vecs[0]  = '{1'b1, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h000, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'd5, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 32'h000, 16'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd5, 1'b1, 11'd1, 1'b0, 1'b0, 1'b0, 32'h000, 16'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'd5, 1'b1, 11'd2, 1'b0, 1'b1, 1'b0, 32'h100, 16'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'd5, 1'b1, 11'd3, 1'b0, 1'b1, 1'b0, 32'h101, 16'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'd5, 1'b1, 11'd4, 1'b1, 1'b1, 1'b0, 32'h102, 16'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 32'h103, 16'd4, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 32'h104, 16'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h104, 16'd5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h104, 16'd5, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h104, 16'd5, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'd5, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'h104, 16'd5, 1'b0, 1'b0};

    $display("[TB] table: single ch0 line, WC=5");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_en0", i),   64'(bus.rd_en_ch0_o),      64'(vecs[i].en0));
      checkOutput($sformatf("v%0d_addr0", i), 64'(bus.rd_addr_ch0_o),    64'(vecs[i].addr0));
      checkOutput($sformatf("v%0d_ack0", i),  64'(bus.line_ack_ch0_o),   64'(vecs[i].ack0));
      checkOutput($sformatf("v%0d_wdv0", i),  64'(bus.lbfr_wdvalid_ch0), 64'(vecs[i].wdv0));
      checkOutput($sformatf("v%0d_last0", i), 64'(bus.lbf_lastwd_ch0),   64'(vecs[i].last0));
      checkOutput($sformatf("v%0d_data0", i), 64'(bus.byte_bufout_ch0),  64'(vecs[i].data0));
      checkOutput($sformatf("v%0d_cnt0", i),  64'(bus.rd_counter_ch0),   64'(vecs[i].cnt0));
      checkOutput($sformatf("v%0d_en1", i),   64'(bus.rd_en_ch1_o),      64'(vecs[i].en1));
      checkOutput($sformatf("v%0d_wdv1", i),  64'(bus.lbfr_wdvalid_ch1), 64'(vecs[i].wdv1));
      checkOutput($sformatf("v%0d_ack1", i),  64'(bus.line_ack_ch1_o),   64'd0);
      checkOutput($sformatf("v%0d_err", i),   64'(bus.wc_err_o),         64'd0);
    end

    $display("[TB] seq: both ready from reset, WC=3 each");
    doReset();
    bus.line_wc_ch0_i = 16'd3; bus.line_wc_ch1_i = 16'd3;
    left0 = 1; left1 = 1;
    bus.line_rdy_ch0_i = 1'b1; bus.line_rdy_ch1_i = 1'b1;
    repeat (25) stepCycle();
    checkOutput("t2_ack_n", 64'(acks.size()), 64'd2);
    for (int i = 0; i < acks.size() && i < 2; i++)
      checkOutput($sformatf("t2_order%0d", i), 64'(acks[i]), 64'(i));
    checkOutput("t2_first_rd0", 64'(first_rd[0]), 64'd1);
    checkOutput("t2_gap", 64'(first_rd[1] - last_rd[0]), 64'd6);
    checkOutput("t2_words0", 64'(wd_cnt[0]), 64'd3);
    checkOutput("t2_words1", 64'(wd_cnt[1]), 64'd3);
    checkOutput("t2_cnt_last", 64'(cnt_at_last), 64'd3);
    checkOutput("t2_overlap", 64'(overlap_err), 64'd0);
    checkOutput("t2_data", 64'(data_err), 64'd0);
    checkOutput("t2_addr", 64'(addr_err), 64'd0);

    $display("[TB] seq: both ready for four lines");
    doReset();
    bus.line_wc_ch0_i = 16'd2; bus.line_wc_ch1_i = 16'd2;
    left0 = 2; left1 = 2;
    bus.line_rdy_ch0_i = 1'b1; bus.line_rdy_ch1_i = 1'b1;
    repeat (60) stepCycle();
    checkOutput("t3_ack_n", 64'(acks.size()), 64'd4);
    for (int i = 0; i < acks.size() && i < 4; i++)
      checkOutput($sformatf("t3_order%0d", i), 64'(acks[i]), 64'(i % 2));
    checkOutput("t3_words0", 64'(wd_cnt[0]), 64'd4);
    checkOutput("t3_words1", 64'(wd_cnt[1]), 64'd4);
    checkOutput("t3_overlap", 64'(overlap_err), 64'd0);
    checkOutput("t3_last", 64'(last_err), 64'd0);

    $display("[TB] seq: ch1 zero-length line");
    doReset();
    bus.line_wc_ch1_i = 16'd0;
    bus.line_wc_ch0_i = 16'd1;
    left1 = 1;
    bus.line_rdy_ch1_i = 1'b1;
    stepCycle();
    checkOutput("t4_ack1", 64'(bus.line_ack_ch1_o), 64'd1);
    checkOutput("t4_en1", 64'(bus.rd_en_ch1_o), 64'd0);
    left0 = 1;
    repeat (12) stepCycle();
    checkOutput("t4_rd1", 64'(rd_cnt[1]), 64'd0);
    checkOutput("t4_wd1", 64'(wd_cnt[1]), 64'd0);
    checkOutput("t4_ack_n", 64'(acks.size()), 64'd2);
    checkOutput("t4_first_rd0", 64'(first_rd[0]), 64'd7);
    checkOutput("t4_wd0", 64'(wd_cnt[0]), 64'd1);

    $display("[TB] seq: oversize line WC=3000");
    doReset();
    checkOutput("t5_err_before", 64'(bus.wc_err_o), 64'd0);
    bus.line_wc_ch0_i = 16'd3000;
    left0 = 1;
    bus.line_rdy_ch0_i = 1'b1;
    repeat (2070) stepCycle();
    checkOutput("t5_reads", 64'(rd_cnt[0]), 64'd2048);
    checkOutput("t5_addr", 64'(addr_err), 64'd0);
    checkOutput("t5_words", 64'(wd_cnt[0]), 64'd2048);
    checkOutput("t5_data", 64'(data_err), 64'd0);
    checkOutput("t5_last_idx", 64'(last_idx[0]), 64'd2048);
    checkOutput("t5_cnt_last", 64'(cnt_at_last), 64'd2048);
    checkOutput("t5_cnt_hold", 64'(bus.rd_counter_ch0), 64'd2048);
    checkOutput("t5_err", 64'(bus.wc_err_o), 64'd1);
    bus.line_wc_ch1_i = 16'd2;
    left1 = 1;
    bus.line_rdy_ch1_i = 1'b1;
    repeat (12) stepCycle();
    checkOutput("t5_ack_n", 64'(acks.size()), 64'd2);
    checkOutput("t5_err_sticky", 64'(bus.wc_err_o), 64'd1);

    $display("[TB] seq: reset in the middle of a WC=8 line");
    doReset();
    checkOutput("t6_err_cleared", 64'(bus.wc_err_o), 64'd0);
    bus.line_wc_ch0_i = 16'd8;
    left0 = 1;
    bus.line_rdy_ch0_i = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t6_addr_2nd", 64'(bus.rd_addr_ch0_o), 64'd1);
    rst_i = 1'b1;
    stepCycle();
    checkOutput("t6_ctrl_zero",
                64'({bus.rd_en_ch0_o, bus.rd_en_ch1_o, bus.rd_addr_ch0_o, bus.rd_addr_ch1_o,
                     bus.line_ack_ch0_o, bus.line_ack_ch1_o, bus.wc_err_o}), 64'd0);
    checkOutput("t6_data0_zero", 64'(bus.byte_bufout_ch0), 64'd0);
    checkOutput("t6_data1_zero", 64'(bus.byte_bufout_ch1), 64'd0);
    checkOutput("t6_flags_zero",
                64'({bus.lbfr_wdvalid_ch0, bus.lbfr_wdvalid_ch1, bus.lbf_lastwd_ch0,
                     bus.lbf_lastwd_ch1, bus.rd_counter_ch0}), 64'd0);
    checkOutput("t6_no_ack", 64'(acks.size()), 64'd0);
    rst_i = 1'b0;
    resetStats();
    stepCycle();
    checkOutput("t6_reread_en", 64'(bus.rd_en_ch0_o), 64'd1);
    checkOutput("t6_reread_addr", 64'(bus.rd_addr_ch0_o), 64'd0);
    repeat (20) stepCycle();
    checkOutput("t6_reads", 64'(rd_cnt[0]), 64'd8);
    checkOutput("t6_addr", 64'(addr_err), 64'd0);
    checkOutput("t6_words", 64'(wd_cnt[0]), 64'd8);
    checkOutput("t6_last_idx", 64'(last_idx[0]), 64'd8);
    checkOutput("t6_ack_n", 64'(acks.size()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
